// File: rtl/i2c_slave_regs.sv
// I2C slave exposing three 8-bit registers behind an auto-incrementing 2-bit pointer.
// Bus pins are sampled through synchronizers; SDA is driven open-drain via sda_oe.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] slv_reg0,
    output logic [7:0] slv_reg1,
    output logic [7:0] slv_reg2,
    output logic       wr_pulse,
    output logic       busy,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_q, sda_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic        busy_q, busy_d;
    logic [7:0]  reg0_q, reg0_d;
    logic [7:0]  reg1_q, reg1_d;
    logic [7:0]  reg2_q, reg2_d;

    logic       scl_s, scl_p, sda_s, sda_p;
    logic       scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0] rx_byte, rd_byte;
    logic [1:0] ptr_inc;

    // Stages [1:0] synchronize; stage [2] is the previous synchronized value for edges.
    assign scl_s     = scl_q[1];
    assign scl_p     = scl_q[2];
    assign sda_s     = sda_q[1];
    assign sda_p     = sda_q[2];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_evt = scl_s & scl_p & ~sda_s & sda_p;
    assign stop_evt  = scl_s & scl_p & sda_s & ~sda_p;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = ptr_q[1] ? 2'd0 : ptr_q + 2'd1;

    always_comb begin
        case (ptr_q)
            2'd0:    rd_byte = reg0_q;
            2'd1:    rd_byte = reg1_q;
            2'd2:    rd_byte = reg2_q;
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q      <= 3'b111;
            sda_q      <= 3'b111;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            busy_q     <= 1'b0;
            reg0_q     <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
        end else begin
            scl_q      <= {scl_q[1:0], scl};
            sda_q      <= {sda_q[1:0], sda_in};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            wr_pulse_q <= wr_pulse_d;
            busy_q     <= busy_d;
            reg0_q     <= reg0_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        busy_d     = busy_q;
        reg0_d     = reg0_q;
        reg1_d     = reg1_q;
        reg2_d     = reg2_q;

        if (start_evt) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_evt) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    state_d = ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = WAIT_STOP;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[1:0];
                                state_d = PTR_ACK;
                            end else begin
                                case (ptr_q)
                                    2'd0:    reg0_d = rx_byte;
                                    2'd1:    reg1_d = rx_byte;
                                    2'd2:    reg2_d = rx_byte;
                                    default: ;
                                endcase
                                wr_pulse_d = (ptr_q != 2'd3);
                                ptr_d      = ptr_inc;
                                state_d    = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // sda_oe is 0 on entry: first fall starts the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q != ADDR_ACK) begin
                                state_d = WDATA;
                            end else if (rw_q) begin
                                state_d  = RDATA;
                                sda_oe_d = ~rd_byte[7];
                                tx_d     = {rd_byte[6:0], 1'b0};
                            end else begin
                                state_d = PTR;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        // bit_cnt 0 here means the master's ACK just ended: fetch the next byte.
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = ~rd_byte[7];
                            tx_d     = {rd_byte[6:0], 1'b0};
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RDATA_ACK;
                            ptr_d   = ptr_inc;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        bit_cnt_d = '0;
                        state_d   = sda_s ? WAIT_STOP : RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign wr_pulse    = wr_pulse_q;
    assign busy        = busy_q;
    assign slv_reg0    = reg0_q;
    assign slv_reg1    = reg1_q;
    assign slv_reg2    = reg2_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master, a transaction-level register
// model with an expected-read queue, and a per-cycle monitor.
module tb_i2c_slave_regs;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, wr_pulse, busy;
    logic [7:0] r0, r1, r2;
    logic [3:0] dbg_state;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regs #(.SLAVE_ADDR(7'h3A)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl         (scl_m),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .slv_reg0    (r0),
        .slv_reg1    (r1),
        .slv_reg2    (r2),
        .wr_pulse    (wr_pulse),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;
    int         exp_pulses = 0;
    int         base = 0;
    int         scl_run = 0;
    logic       wr_prev = 1'b0;
    logic       oe_prev = 1'b0;
    bit         chk_regs = 1'b0;
    bit         quiet = 1'b0;
    logic [7:0] m_regs [3];
    int         m_ptr = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register model: pointer walks 0,1,2 then wraps; slot 3 reads 0 and swallows writes.
    function automatic int ptr_next(input int p);
        return (p >= 2) ? 0 : p + 1;
    endfunction

    task automatic model_write(input logic [7:0] b);
        if (m_ptr < 3) begin
            m_regs[m_ptr] = b;
            exp_pulses++;
        end
        m_ptr = ptr_next(m_ptr);
    endtask

    task automatic model_read();
        exp_q.push_back((m_ptr < 3) ? m_regs[m_ptr] : 8'h00);
        m_ptr = ptr_next(m_ptr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    // ---------------- clock/reset helpers and bus driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
        end
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic clock_bit(input bit b, output bit s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        s = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string nm);
        bit s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        chk($sformatf("%s_ack", nm), {31'd0, ~s}, {31'd0, exp_ack});
    endtask

    task automatic recv_byte(input bit nack, input string nm, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
        chk($sformatf("%s_expq_nonempty", nm), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk(nm, d, exp_q.pop_front());
    endtask

    // ---------------- scoreboard monitor
    always @(negedge clk) begin
        if (wr_pulse) begin
            wr_cnt++;
            chk("wr_pulse_width", wr_prev, 0);
        end
        wr_prev = wr_pulse;
        scl_run = scl_m ? scl_run + 1 : 0;
        if (!reset && scl_run >= 8) chk("sda_oe_stable_scl_high", sda_oe, oe_prev);
        oe_prev = sda_oe;
        if (chk_regs && !reset) begin
            chk("model_reg0", r0, m_regs[0]);
            chk("model_reg1", r1, m_regs[1]);
            chk("model_reg2", r2, m_regs[2]);
        end
        if (quiet) begin
            chk("wrong_addr_sda_oe", sda_oe, 0);
            chk("wrong_addr_busy", busy, 0);
        end
    end

    // ---------------- directed stimulus
    initial begin
        model_reset();
        reset = 1'b1;
        tick(4);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_reg0", r0, 8'h00);
        chk("rst_reg1", r1, 8'h00);
        chk("rst_reg2", r2, 8'h00);
        chk("rst_state", dbg_state, 4'd0);
        reset = 1'b0;
        tick(4);
        chk_regs = 1'b1;

        // Burst write of three registers from pointer 0.
        base = wr_cnt; chk_regs = 1'b0;
        bus_start();
        send_byte(8'h74, 1'b1, "w1_addr");
        chk("w1_busy", busy, 1);
        send_byte(8'h00, 1'b1, "w1_ptr"); m_ptr = 0;
        send_byte(8'h12, 1'b1, "w1_d0"); model_write(8'h12);
        send_byte(8'h34, 1'b1, "w1_d1"); model_write(8'h34);
        send_byte(8'h56, 1'b1, "w1_d2"); model_write(8'h56);
        bus_stop();
        chk_regs = 1'b1;
        chk("w1_reg0", r0, 8'h12);
        chk("w1_reg1", r1, 8'h34);
        chk("w1_reg2", r2, 8'h56);
        chk("w1_pulses", wr_cnt - base, 3);
        chk("w1_busy_after_stop", busy, 0);
        chk("w1_idle", dbg_state, 4'd0);

        // Set pointer to 1, repeated START, read three bytes wrapping past reg2.
        base = wr_cnt; chk_regs = 1'b0;
        bus_start();
        send_byte(8'h74, 1'b1, "r_waddr");
        send_byte(8'h01, 1'b1, "r_ptr"); m_ptr = 1;
        bus_start();
        send_byte(8'h75, 1'b1, "r_raddr");
        chk("r_busy", busy, 1);
        model_read(); model_read(); model_read();
        recv_byte(1'b0, "r_byte0", rd); chk("r_byte0_lit", rd, 8'h34);
        recv_byte(1'b0, "r_byte1", rd); chk("r_byte1_lit", rd, 8'h56);
        recv_byte(1'b1, "r_byte2", rd); chk("r_byte2_lit", rd, 8'h12);
        bus_stop();
        chk_regs = 1'b1;
        chk("r_pulses", wr_cnt - base, 0);
        chk("r_busy_after_stop", busy, 0);

        // Foreign address: slave must stay silent and idle.
        quiet = 1'b1;
        bus_start();
        send_byte(8'h50, 1'b0, "wa_addr");
        send_byte(8'hFF, 1'b0, "wa_data");
        bus_stop();
        quiet = 1'b0;
        chk("wa_reg0", r0, 8'h12);
        chk("wa_reg1", r1, 8'h34);
        chk("wa_reg2", r2, 8'h56);

        // Pointer 3: first byte discarded, second lands in reg0.
        base = wr_cnt; chk_regs = 1'b0;
        bus_start();
        send_byte(8'h74, 1'b1, "p3_addr");
        send_byte(8'h03, 1'b1, "p3_ptr"); m_ptr = 3;
        send_byte(8'hAA, 1'b1, "p3_d0"); model_write(8'hAA);
        send_byte(8'hBB, 1'b1, "p3_d1"); model_write(8'hBB);
        bus_stop();
        chk_regs = 1'b1;
        chk("p3_reg0", r0, 8'hBB);
        chk("p3_reg1", r1, 8'h34);
        chk("p3_reg2", r2, 8'h56);
        chk("p3_pulses", wr_cnt - base, 1);

        // STOP in the middle of a data byte.
        base = wr_cnt; chk_regs = 1'b0;
        bus_start();
        send_byte(8'h74, 1'b1, "ms_addr");
        send_byte(8'h00, 1'b1, "ms_ptr"); m_ptr = 0;
        begin
            bit s;
            logic [7:0] part;
            part = 8'h99;
            for (int i = 7; i >= 4; i--) clock_bit(part[i], s);
        end
        bus_stop();
        chk_regs = 1'b1;
        chk("ms_busy", busy, 0);
        chk("ms_idle", dbg_state, 4'd0);
        chk("ms_pulses", wr_cnt - base, 0);
        chk("ms_reg0", r0, 8'hBB);

        // Reset during the 4th bit of a data byte, then a clean write.
        chk_regs = 1'b0;
        bus_start();
        send_byte(8'h74, 1'b1, "rr_addr");
        send_byte(8'h00, 1'b1, "rr_ptr");
        begin
            bit s;
            clock_bit(1'b1, s);
            clock_bit(1'b1, s);
            clock_bit(1'b0, s);
        end
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(2);
        reset = 1'b1;
        tick(1);
        chk("rr_sda_oe", sda_oe, 0);
        chk("rr_reg0", r0, 8'h00);
        chk("rr_reg1", r1, 8'h00);
        chk("rr_reg2", r2, 8'h00);
        chk("rr_busy", busy, 0);
        chk("rr_idle", dbg_state, 4'd0);
        reset = 1'b0;
        sda_m = 1'b1;
        model_reset();
        tick(2 * Q);
        chk_regs = 1'b1;

        base = wr_cnt; chk_regs = 1'b0;
        bus_start();
        send_byte(8'h74, 1'b1, "pr_addr");
        send_byte(8'h01, 1'b1, "pr_ptr"); m_ptr = 1;
        send_byte(8'h5A, 1'b1, "pr_d0"); model_write(8'h5A);
        bus_stop();
        chk_regs = 1'b1;
        chk("pr_reg0", r0, 8'h00);
        chk("pr_reg1", r1, 8'h5A);
        chk("pr_reg2", r2, 8'h00);
        chk("pr_pulses", wr_cnt - base, 1);

        tick(4);
        chk("total_pulses", wr_cnt, exp_pulses);
        chk("total_pulses_lit", wr_cnt, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h3A, the 7-bit I2C device address.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port scl, input, 1 bit: raw I2C clock from the pad, asynchronous to clk.
REQ-005 SHALL have port sda_in, input, 1 bit: raw I2C data from the pad, asynchronous to clk.
REQ-006 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-007 SHALL have ports slv_reg0, slv_reg1 and slv_reg2, output, 8 bits each: the register file contents consumed by the display stage.
REQ-008 SHALL have port wr_pulse, output, 1 bit: a 1-clk pulse each time a register byte is written.
REQ-009 SHALL have port busy, output, 1 bit: 1 from an addressed START until the STOP or the return to IDLE.

Function
REQ-010 SHALL pass scl and sda_in through 2-flop synchronizers and SHALL derive rise/fall events from a third stage; all decisions use only the synchronized values.
REQ-011 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-012 SHALL implement the FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT_STOP.
REQ-013 SHALL, on START in any state including a repeated START, clear the bit counter and enter ADDR.
REQ-014 SHALL, on STOP in any state, release sda_oe and enter IDLE within 1 clk.
REQ-015 SHALL, in all receive states, shift SDA in MSB-first on each SCL rising edge; the 8th bit completes the byte.
REQ-016 SHALL, in ADDR, compare byte[7:1] with SLAVE_ADDR: on a match go to ADDR_ACK and latch the R/W bit (byte[0]); on a mismatch go to WAIT_STOP with sda_oe held at 0.
REQ-017 SHALL, in each ACK state, assert sda_oe from the SCL falling edge after the 8th bit until the next SCL falling edge, then release it.
REQ-018 SHALL, after ADDR_ACK, go to PTR if R/W=0 and to RDATA if R/W=1.
REQ-019 SHALL hold a 2-bit pointer loaded from PTR byte[1:0]; bits [7:2] are ignored.
REQ-020 SHALL, in WDATA, complete a byte and then, at the ACK state entry:
- write the byte to slv_reg[ptr];
- pulse wr_pulse for 1 clk;
- increment ptr.
REQ-021 SHALL, for the pointer, use an increment sequence 0->1->2->0 with 3->0; a write to ptr=3 is ACKed, discarded, and does not pulse wr_pulse.
REQ-022 SHALL, in RDATA, load slv_reg[ptr] (0x00 for ptr=3) at the SCL falling edge ending the previous ACK.
REQ-023 SHALL, in RDATA, drive each bit MSB-first on SCL falling edges (sda_oe = ~bit) and increment ptr after the 8th bit.
REQ-024 SHALL, in RDATA_ACK, release SDA and sample the master's bit on the SCL rising edge: 0 (ACK) returns to RDATA; 1 (NACK) goes to WAIT_STOP.
REQ-025 SHALL change sda_oe only in response to synchronized SCL-low events, never while synchronized SCL is high.
REQ-026 SHALL, in WAIT_STOP, ignore all traffic except START and STOP.

Reset
REQ-027 SHALL, on reset, set:
- the FSM to IDLE;
- sda_oe, wr_pulse and busy to 0;
- slv_reg0, slv_reg1 and slv_reg2 to 8'h00;
- ptr, the bit counter and the shift register to 0;
- the synchronizers to 1 (idle bus).
REQ-028 SHALL, when reset is asserted mid-transfer, abort the transfer with SDA released within 1 clk; registers already written are cleared to 0.

Verification
REQ-029 SHALL be verified with: START, 0x74 (0x3A+W), 0x00, 0x12, 0x34, 0x56, STOP -> all 5 bytes ACKed; slv_reg0=0x12, slv_reg1=0x34, slv_reg2=0x56; 3 wr_pulse pulses.
REQ-030 SHALL be verified with: after REQ-029, START 0x74 0x01, repeated START 0x75, master reads 3 bytes ACK/ACK/NACK, STOP -> reads return 0x34, 0x56, 0x12 (wrap).
REQ-031 SHALL be verified with: START, 0x50 (wrong address), 0xFF, STOP -> sda_oe stays 0 throughout; registers unchanged; busy stays 0.
REQ-032 SHALL be verified with: START 0x74 0x03 0xAA 0xBB STOP -> all bytes ACKed; 0xAA discarded; slv_reg0=0xBB; exactly 1 wr_pulse pulse.
REQ-033 SHALL be verified with: reset asserted during the 4th bit of a WDATA byte -> next clk sda_oe=0 and all slv_reg=0x00; a following complete write succeeds.
REQ-034 SHALL be verified with: STOP issued mid-byte in WDATA -> FSM returns to IDLE; the partial byte is not written; no wr_pulse.
